// File: rtl/clk_divider.sv
// Integer clock divider: registered divided clock, fast-domain tick aligned
// with each clk_out rising edge, and the current phase counter.
module clk_divider #(
  parameter int DIV_BY = 4,
  parameter int CW     = $clog2(DIV_BY)
) (
  input  logic          in_clk,
  input  logic          rst,
  input  logic          en,
  output logic          clk_out,
  output logic          tick,
  output logic [CW-1:0] phase
);

  if (DIV_BY < 2) begin : g_bad_div_by
    $error("clk_divider: DIV_BY must be >= 2");
  end

  localparam int            HI        = DIV_BY / 2;
  localparam logic [CW-1:0] LAST      = CW'(DIV_BY - 1);
  localparam logic [CW-1:0] HIGH_LAST = CW'(HI - 1);

  logic [CW-1:0] phase_q, phase_d;
  logic          clk_out_q, clk_out_d;
  logic          tick_q, tick_d;

  // The wrap test takes priority so DIV_BY=2, where HIGH_LAST is 0, still
  // toggles every edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    phase_d   = phase_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (en) begin
      if (phase_q == LAST) begin
        phase_d   = '0;
        clk_out_d = 1'b1;
        tick_d    = 1'b1;
      end else begin
        phase_d = phase_q + 1'b1;
        if (phase_q == HIGH_LAST) begin
          clk_out_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge in_clk) begin
    // NOTE: state registers use non-blocking assignments so all of them
    // sample pre-edge values regardless of statement order.
    if (rst) begin
      phase_q   <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign clk_out = clk_out_q;
  assign tick    = tick_q;
  assign phase   = phase_q;

endmodule

// File: tb/tb_clk_divider.sv
// Self-checking bench for clk_divider at DIV_BY = 4, 3 and 2 sharing one clock,
// reset and enable; expectations come from an enabled-edge count per instance.
module tb_clk_divider;

  typedef struct {
    string tag;
    int    inst;
    int    phase;
    logic  clk_out;
    logic  tick;
  } exp_t;

  logic       in_clk = 1'b0;
  logic       rst    = 1'b1;
  logic       en     = 1'b1;
  logic       clk4, clk3, clk2;
  logic       tick4, tick3, tick2;
  logic [1:0] ph4, ph3;
  logic       ph2;

  exp_t sb[$];
  int   div_tab [3] = '{4, 3, 2};
  int   n_en    [3] = '{0, 0, 0};
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 in_clk = ~in_clk;

  clk_divider #(.DIV_BY(4)) u_div4 (
    .in_clk(in_clk), .rst(rst), .en(en), .clk_out(clk4), .tick(tick4), .phase(ph4)
  );
  clk_divider #(.DIV_BY(3)) u_div3 (
    .in_clk(in_clk), .rst(rst), .en(en), .clk_out(clk3), .tick(tick3), .phase(ph3)
  );
  clk_divider #(.DIV_BY(2)) u_div2 (
    .in_clk(in_clk), .rst(rst), .en(en), .clk_out(clk2), .tick(tick2), .phase(ph2)
  );

  // After n enabled edges since reset: phase = n mod D; clk_out has risen once
  // n reaches D and is high for the first floor(D/2) counts of each period.
  function automatic exp_t predict(string tag, int inst, int n, int d, logic ticked);
    exp_t e;
    e.tag     = tag;
    e.inst    = inst;
    e.phase   = n % d;
    e.clk_out = (n >= d) && ((n % d) < (d / 2));
    e.tick    = ticked;
    return e;
  endfunction

  task automatic check_one(exp_t e);
    int   obs_phase;
    logic obs_clk, obs_tick;
    case (e.inst)
      0:       begin obs_phase = int'(ph4); obs_clk = clk4; obs_tick = tick4; end
      1:       begin obs_phase = int'(ph3); obs_clk = clk3; obs_tick = tick3; end
      default: begin obs_phase = int'(ph2); obs_clk = clk2; obs_tick = tick2; end
    endcase
    vectors++;
    assert (obs_phase === e.phase) else begin
      miscompares++;
      $error("FAIL %s div%0d phase: observed %0d expected %0d",
             e.tag, div_tab[e.inst], obs_phase, e.phase);
    end
    vectors++;
    assert (obs_clk === e.clk_out) else begin
      miscompares++;
      $error("FAIL %s div%0d clk_out: observed %b expected %b",
             e.tag, div_tab[e.inst], obs_clk, e.clk_out);
    end
    vectors++;
    assert (obs_tick === e.tick) else begin
      miscompares++;
      $error("FAIL %s div%0d tick: observed %b expected %b",
             e.tag, div_tab[e.inst], obs_tick, e.tick);
    end
  endtask

  // Drive one cycle of stimulus, push the expected post-edge state of every
  // instance, then pop and compare 1 time unit after the edge.
  task automatic step(string tag, logic r, logic e);
    logic ticked;
    rst = r;
    en  = e;
    for (int i = 0; i < 3; i++) begin
      ticked = 1'b0;
      if (r) begin
        n_en[i] = 0;
      end else if (e) begin
        n_en[i]++;
        ticked = (n_en[i] % div_tab[i]) == 0;
      end
      sb.push_back(predict(tag, i, n_en[i], div_tab[i], ticked));
    end
    @(posedge in_clk);
    #1;
    while (sb.size() > 0) begin
      check_one(sb.pop_front());
    end
  endtask

  initial begin
    // Reset, including reset with en low.
    step("reset", 1'b1, 1'b1);
    step("reset_en0", 1'b1, 1'b0);

    // Free run: clk_out/tick/phase patterns for all three ratios.
    for (int k = 0; k < 12; k++) step("run", 1'b0, 1'b1);

    // DIV_BY=4 now at phase 0; one more edge gives phase 1 with clk_out high.
    step("to_phase1", 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) step("freeze", 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) step("resume", 1'b0, 1'b1);

    // Single-cycle enable gaps in the middle of periods.
    for (int k = 0; k < 8; k++) step("en_toggle", 1'b0, logic'(k % 2 == 0));

    // Bring DIV_BY=4 to phase 0 with clk_out high, then reset mid-high-phase.
    while ((n_en[0] % 4) != 0) step("align", 1'b0, 1'b1);
    step("reset_mid", 1'b1, 1'b1);
    for (int k = 0; k < 9; k++) step("restart", 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
